// File: rtl/next_pc_predictor.sv
// Tagged next-PC predictor: zero-latency lookup for fetch, write-back of resolved
// control transfers, saturating confidence, bulk invalidate and occupancy count.
module next_pc_predictor #(
    parameter int DBITS   = 16,
    parameter int IBITS   = 8,
    parameter int TBITS   = 4,
    parameter int CBITS   = 2,
    parameter int PCALIGN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DBITS-1:0] lkpc,
    output logic [DBITS-1:0] predpc,
    output logic             predhit,
    input  logic             upden,
    input  logic [DBITS-1:0] updpc,
    input  logic [DBITS-1:0] updtarg,
    input  logic             updtaken,
    input  logic             invall,
    output logic [IBITS:0]   occ
);

    localparam int               ENTRIES  = 2**IBITS;
    localparam logic [DBITS-1:0] SEQ_STEP = DBITS'(2**PCALIGN);
    localparam logic [CBITS-1:0] CTR_MAX  = {CBITS{1'b1}};
    localparam logic [CBITS-1:0] CTR_WEAK = CBITS'(2**(CBITS-1));

    logic [TBITS-1:0] tag_mem    [ENTRIES];
    logic [DBITS-1:0] target_mem [ENTRIES];
    logic [CBITS-1:0] ctr_mem    [ENTRIES];

    logic [ENTRIES-1:0] valid_reg;
    logic [ENTRIES-1:0] valid_next;
    logic [IBITS:0]     occ_reg;

    logic [IBITS-1:0] lk_idx;
    logic [TBITS-1:0] lk_tag;
    logic [IBITS-1:0] up_idx;
    logic [TBITS-1:0] up_tag;
    logic             up_match;
    logic             up_write;
    logic             up_alloc;
    logic             up_mem_we;
    logic [CBITS-1:0] ctr_next;
    logic             updpc_unused;

    assign lk_idx = lkpc[PCALIGN +: IBITS];
    assign lk_tag = lkpc[PCALIGN+IBITS +: TBITS];
    assign up_idx = updpc[PCALIGN +: IBITS];
    assign up_tag = updpc[PCALIGN+IBITS +: TBITS];
    // Alignment and untagged high bits of the update PC play no part in the entry
    assign updpc_unused = ^updpc;

    // Lookup reads the table as it stands this cycle; updates land only at the edge
    assign predhit = valid_reg[lk_idx] && (tag_mem[lk_idx] == lk_tag) && ctr_mem[lk_idx][CBITS-1];
    assign predpc  = predhit ? target_mem[lk_idx] : lkpc + SEQ_STEP;
    assign occ     = occ_reg;

    assign up_match  = valid_reg[up_idx] && (tag_mem[up_idx] == up_tag);
    assign up_write  = rst_n && upden && !invall;
    assign up_alloc  = up_write && !up_match && updtaken;
    assign up_mem_we = up_write && (up_match || updtaken);

    always_comb begin
        ctr_next = ctr_mem[up_idx];
        if (up_alloc) begin
            ctr_next = CTR_WEAK;
        end else if (up_match && updtaken) begin
            if (ctr_mem[up_idx] != CTR_MAX) ctr_next = ctr_mem[up_idx] + CBITS'(1);
        end else if (up_match) begin
            if (ctr_mem[up_idx] != '0) ctr_next = ctr_mem[up_idx] - CBITS'(1);
        end
    end

    // Tag/target/counter storage carries no reset; the valid vector guards it
    always_ff @(posedge clk) begin
        if (up_mem_we) begin
            ctr_mem[up_idx] <= ctr_next;
            if (updtaken) target_mem[up_idx] <= updtarg;
            if (up_alloc) tag_mem[up_idx] <= up_tag;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_valid
            assign valid_next[gi] = invall ? 1'b0 :
                                    ((up_alloc && (up_idx == IBITS'(gi))) ? 1'b1 : valid_reg[gi]);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= '0;
            occ_reg   <= '0;
        end else begin
            valid_reg <= valid_next;
            if (invall) begin
                occ_reg <= '0;
            end else if (up_alloc && !valid_reg[up_idx]) begin
                occ_reg <= occ_reg + (IBITS+1)'(1);
            end
        end
    end

endmodule
